// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        OpNop  = 4'd0,
        OpAdd  = 4'd1,
        OpSub  = 4'd2,
        OpMul  = 4'd3,
        OpAnd  = 4'd4,
        OpOr   = 4'd5,
        OpXor  = 4'd6,
        OpXnor = 4'd7,
        OpShl  = 4'd8,
        OpShr  = 4'd9,
        OpInc  = 4'd10,
        OpDec  = 4'd11,
        OpDiv  = 4'd12,
        OpMod  = 4'd13,
        OpSra  = 4'd14,
        OpIll  = 4'd15
    } alu_op_t;

    localparam int unsigned ST_EQ    = 0;
    localparam int unsigned ST_NE    = 1;
    localparam int unsigned ST_GT    = 2;
    localparam int unsigned ST_GE    = 3;
    localparam int unsigned ST_LT    = 4;
    localparam int unsigned ST_LE    = 5;
    localparam int unsigned ST_CARRY = 6;
    localparam int unsigned ST_ERR   = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative shift-add multiplier and restoring divider; one step per cycle, WIDTH steps.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] quo_prod,
    output logic [WIDTH-1:0] rem
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic             running_q;
    logic             is_mul_q;
    logic [CW-1:0]    count_q;
    // acc: product or partial remainder; shr: multiplier or dividend/quotient;
    // opd: shifting multiplicand or divisor.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] shr_q, shr_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   diff;

    always_comb begin
        acc_d   = acc_q;
        shr_d   = shr_q;
        opd_d   = opd_q;
        r_shift = {acc_q, shr_q[WIDTH-1]};
        diff    = r_shift - {1'b0, opd_q};
        if (is_mul_q) begin
            if (shr_q[0]) begin
                acc_d = acc_q + opd_q;
            end
            shr_d = shr_q >> 1;
            opd_d = opd_q << 1;
        end else if (!diff[WIDTH]) begin
            acc_d = diff[WIDTH-1:0];
            shr_d = {shr_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_d = r_shift[WIDTH-1:0];
            shr_d = {shr_q[WIDTH-2:0], 1'b0};
        end
    end

    // Results are the post-step values so the final step lands in the output register directly.
    assign done     = running_q && (count_q == '0);
    assign quo_prod = is_mul_q ? acc_d : shr_d;
    assign rem      = acc_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            is_mul_q  <= 1'b0;
            count_q   <= '0;
            acc_q     <= '0;
            shr_q     <= '0;
            opd_q     <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            is_mul_q  <= (op == OpMul);
            count_q   <= CW'(WIDTH - 1);
            acc_q     <= '0;
            shr_q     <= (op == OpMul) ? b : opa;
            opd_q     <= (op == OpMul) ? opa : b;
        end else if (running_q) begin
            acc_q <= acc_d;
            shr_q <= shr_d;
            opd_q <= opd_d;
            if (count_q == '0) begin
                running_q <= 1'b0;
            end else begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: valid/ready request, single-cycle datapath, iterative MUL/DIV/MOD, held result.
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm_val,
    input  logic             imm,
    input  logic [3:0]       func,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [7:0]       status_reg
);

    state_t           state_q, state_d;
    alu_op_t          func_in, func_q;
    logic [WIDTH-1:0] opa_in, opa_q, b_q;
    logic             accept, iter_start, load;

    logic [SHW-1:0]   shamt;
    logic             shbig;
    logic [WIDTH-1:0] sc_res;
    logic             sc_carry, sc_err;

    logic             it_done;
    logic [WIDTH-1:0] it_qp, it_rem;

    logic [WIDTH-1:0] fx, fy, res;
    logic             carry, err, eq, gt, lt;
    logic [7:0]       flags;

    assign opa_in  = imm ? imm_val : a;
    assign func_in = alu_op_t'(func);
    assign accept  = (state_q == IDLE) && in_valid;
    assign iter_start = accept && ((func_in == OpMul) ||
                        (((func_in == OpDiv) || (func_in == OpMod)) && (b != '0)));

    assign shamt = b[SHW-1:0];
    assign shbig = |b[WIDTH-1:SHW];

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_err   = 1'b0;
        case (func_in)
            OpNop:  sc_res = opa_in;
            OpAdd:  {sc_carry, sc_res} = {1'b0, opa_in} + {1'b0, b};
            OpSub:  {sc_carry, sc_res} = {1'b0, opa_in} - {1'b0, b};
            OpMul:  sc_res = '0;
            OpAnd:  sc_res = opa_in & b;
            OpOr:   sc_res = opa_in | b;
            OpXor:  sc_res = opa_in ^ b;
            OpXnor: sc_res = ~(opa_in ^ b);
            OpShl:  sc_res = shbig ? '0 : (opa_in << shamt);
            OpShr:  sc_res = shbig ? '0 : (opa_in >> shamt);
            OpInc:  {sc_carry, sc_res} = {1'b0, opa_in} + {{WIDTH{1'b0}}, 1'b1};
            OpDec:  {sc_carry, sc_res} = {1'b0, opa_in} - {{WIDTH{1'b0}}, 1'b1};
            OpDiv: begin
                sc_err = (b == '0);
                sc_res = '1;
            end
            OpMod: begin
                sc_err = (b == '0);
                sc_res = opa_in;
            end
            OpSra:  sc_res = shbig ? {WIDTH{opa_in[WIDTH-1]}}
                                   : $unsigned($signed(opa_in) >>> shamt);
            default: begin
                sc_err = 1'b1;
                sc_res = '0;
            end
        endcase
    end

    alu_iter_muldiv #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (iter_start),
        .op       (func_in),
        .opa      (opa_in),
        .b        (b),
        .done     (it_done),
        .quo_prod (it_qp),
        .rem      (it_rem)
    );

    // Flags come from live operands on a single-cycle completion, captured ones after BUSY.
    always_comb begin
        if (state_q == BUSY) begin
            fx    = opa_q;
            fy    = b_q;
            res   = (func_q == OpMod) ? it_rem : it_qp;
            carry = 1'b0;
            err   = 1'b0;
        end else begin
            fx    = opa_in;
            fy    = b;
            res   = sc_res;
            carry = sc_carry;
            err   = sc_err;
        end
        eq = (res == '0);
        gt = (fx > fy);
        lt = (fx < fy);
        flags           = '0;
        flags[ST_EQ]    = eq;
        flags[ST_NE]    = !eq;
        flags[ST_GT]    = gt;
        flags[ST_GE]    = gt | eq;
        flags[ST_LT]    = lt;
        flags[ST_LE]    = lt | eq;
        flags[ST_CARRY] = carry;
        flags[ST_ERR]   = err;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (iter_start) begin
                        state_d = BUSY;
                    end else begin
                        state_d = DONE;
                        load    = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (it_done) begin
                    state_d = DONE;
                    load    = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            opa_q      <= '0;
            b_q        <= '0;
            func_q     <= OpNop;
            out        <= '0;
            status_reg <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                opa_q  <= opa_in;
                b_q    <= b;
                func_q <= func_in;
            end
            if (load) begin
                out        <= res;
                status_reg <= flags;
            end
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases plus random ops against an arithmetic model.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b, imm_val;
    logic        imm;
    logic [3:0]  func;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic [7:0]  status_reg;

    int total = 0;
    int bad   = 0;

    alu_mc #(
        .WIDTH (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .imm_val    (imm_val),
        .imm        (imm),
        .func       (func),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .status_reg (status_reg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns {status, result} computed directly from the opcode table and flag rules.
    function automatic logic [39:0] ref_model(input int op, input logic [31:0] x,
                                              input logic [31:0] y);
        longint unsigned ux, uy, r, mask;
        bit c, e, eq, gt, lt;
        ux = 64'(x);
        uy = 64'(y);
        mask = 64'hFFFF_FFFF;
        c = 0;
        e = 0;
        r = 0;
        case (op)
            0:  r = ux;
            1:  begin r = ux + uy; c = (r > mask); end
            2:  begin c = (ux < uy); r = ux - uy; end
            3:  r = ux * uy;
            4:  r = ux & uy;
            5:  r = ux | uy;
            6:  r = ux ^ uy;
            7:  r = ~(ux ^ uy);
            8:  r = (uy >= 32) ? 0 : (ux << uy);
            9:  r = (uy >= 32) ? 0 : (ux >> uy);
            10: begin r = ux + 1; c = (ux == mask); end
            11: begin r = ux - 1; c = (ux == 0); end
            12: if (uy == 0) begin e = 1; r = mask; end else r = ux / uy;
            13: if (uy == 0) begin e = 1; r = ux; end else r = ux % uy;
            14: if (uy >= 32) r = x[31] ? mask : 0;
                else r = (ux >> uy) | (x[31] ? ((mask << (32 - uy)) & mask) : 0);
            default: begin e = 1; r = 0; end
        endcase
        r  = r & mask;
        eq = (r == 0);
        gt = (ux > uy);
        lt = (ux < uy);
        return {e, c, lt | eq, lt, gt | eq, gt, !eq, eq, r[31:0]};
    endfunction

    // Issue one op from a negedge in IDLE, verify latency/result/hold, then release it.
    task automatic do_op(input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv,
                         input logic im, input logic [31:0] iv, input int stall,
                         output logic [31:0] got_out, output logic [7:0] got_st);
        logic [31:0] opa;
        logic [39:0] m;
        int lat, cyc;
        bit rdy_seen;
        opa = im ? iv : av;
        m   = ref_model(int'(f), opa, bv);
        lat = ((f == 4'd3) || (((f == 4'd12) || (f == 4'd13)) && (bv != 0))) ? 33 : 1;
        check("idle_ready", 64'(in_ready), 64'(1));
        func = f; a = av; b = bv; imm = im; imm_val = iv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        a = $urandom; b = $urandom; imm_val = $urandom; imm = 1'($urandom);
        func = 4'($urandom); in_valid = 1'($urandom);
        cyc = 0;
        rdy_seen = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (in_ready) rdy_seen = 1;
        end while (!out_valid && cyc < 60);
        check("latency", 64'(cyc), 64'(lat));
        check("busy_ready", 64'(rdy_seen), 64'(0));
        check("out", 64'(out), 64'(m[31:0]));
        check("status", 64'(status_reg), 64'(m[39:32]));
        got_out = out;
        got_st  = status_reg;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("hold", {22'd0, out_valid, in_ready, out, status_reg},
                  {22'd0, 1'b1, 1'b0, got_out, got_st});
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        check("release", {62'd0, in_ready, out_valid}, {62'd0, 2'b10});
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] ro;
        logic [7:0]  rs;
        int vcount;

        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        a = 32'h1234; b = 32'h5; imm = 1'b0; imm_val = '0; func = 4'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out", 64'(out), 64'(0));
        check("rst_status", 64'(status_reg), 64'(0));
        check("rst_valid", 64'(out_valid), 64'(0));
        check("rst_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst", {62'd0, in_ready, out_valid}, {62'd0, 2'b10});

        do_op(4'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0, 0, ro, rs);
        check("add_carry_out", 64'(ro), 64'(0));
        check("add_carry_st", 64'(rs), 64'(8'h6D));

        do_op(4'd2, 32'd100, 32'd7, 1'b1, 32'd7, 5, ro, rs);
        check("imm_sub_out", 64'(ro), 64'(0));
        check("imm_sub_st", 64'(rs), 64'(8'h29));

        do_op(4'd3, 32'h0001_0000, 32'h0001_0003, 1'b0, 32'd0, 1, ro, rs);
        check("mul_out", 64'(ro), 64'(32'h0003_0000));

        do_op(4'd12, 32'd100, 32'd7, 1'b0, 32'd0, 0, ro, rs);
        check("div_out", 64'(ro), 64'(14));
        do_op(4'd13, 32'd100, 32'd7, 1'b0, 32'd0, 0, ro, rs);
        check("mod_out", 64'(ro), 64'(2));
        do_op(4'd12, 32'd100, 32'd0, 1'b0, 32'd0, 0, ro, rs);
        check("div0_out", {56'd0, rs[7], ro[6:0]}, {56'd0, 1'b1, 7'h7F});
        check("div0_full", 64'(ro), 64'(32'hFFFF_FFFF));
        do_op(4'd13, 32'd100, 32'd0, 1'b0, 32'd0, 0, ro, rs);
        check("mod0_out", {31'd0, rs[7], ro}, {31'd0, 1'b1, 32'd100});

        do_op(4'd14, 32'h8000_0000, 32'd40, 1'b0, 32'd0, 0, ro, rs);
        check("sra_big", 64'(ro), 64'(32'hFFFF_FFFF));
        do_op(4'd8, 32'hDEAD_BEEF, 32'd32, 1'b0, 32'd0, 0, ro, rs);
        check("shl_32", 64'(ro), 64'(0));
        do_op(4'd15, 32'd55, 32'd3, 1'b0, 32'd0, 0, ro, rs);
        check("illegal", {31'd0, rs[7], ro}, {31'd0, 1'b1, 32'd0});

        // Reset pulse in the middle of a multiply must drop the operation.
        func = 4'd3; a = 32'd12345; b = 32'd678; imm = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        check("abort_no_valid", 64'(vcount), 64'(0));
        do_op(4'd1, 32'd20, 32'd22, 1'b0, 32'd0, 0, ro, rs);
        check("after_abort", 64'(ro), 64'(42));

        for (int i = 0; i < 40; i++) begin
            logic [3:0]  rf;
            logic [31:0] ra, rb;
            rf = 4'($urandom_range(0, 15));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = 32'($urandom_range(0, 40));
                2: rb = 32'd0;
                default: rb = ra;
            endcase
            do_op(rf, ra, rb, 1'($urandom), ra, int'($urandom_range(0, 2)), ro, rs);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
